// File: rtl/count_event_monitor.sv
// Observer for the 10-bit up/down counter: flags wrap, direction change and illegal
// steps, and queues timestamped {type, cnt, ts} records for a valid/ready consumer.
module count_event_monitor #(
   parameter int DEPTH = 4,
   parameter int TS_W  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [9:0]           cnt,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [12+TS_W-1:0]   evt_data,
   output logic                 ovf,
   output logic [7:0]           drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = 12 + TS_W;

   typedef enum logic [1:0] {
      EVT_WRAP = 2'b00,
      EVT_DIR  = 2'b01,
      EVT_JUMP = 2'b10
   } evt_type_t;

   logic [9:0]      cnt_q;
   logic [9:0]      exp_cnt;
   logic            mode_q;
   logic            primed;
   logic [TS_W-1:0] ts;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     occ;
   logic            is_jump;
   logic            is_wrap;
   logic            is_dir;
   logic            push;
   logic            pop;
   logic            full;
   logic            do_write;
   logic            drop;
   evt_type_t       evt_type;

   // The expected step follows the previous mode; a mode flip only shows up as DIR.
   always_comb begin
      exp_cnt  = mode_q ? cnt_q + 10'd1 : cnt_q - 10'd1;
      is_jump  = (cnt != exp_cnt);
      is_wrap  = !is_jump && (mode_q ? (cnt_q == 10'h3FF) : (cnt_q == 10'h000));
      is_dir   = (mode != mode_q);
      evt_type = EVT_DIR;
      if (is_jump)
         evt_type = EVT_JUMP;
      else if (is_wrap)
         evt_type = EVT_WRAP;
      push = primed && (is_jump || is_wrap || is_dir);
   end

   // Handshake: a record transfers in any cycle where evt_valid and evt_ready are both high;
   // evt_valid/evt_data are register-driven and hold until that transfer.
   assign evt_valid = (occ != '0);
   assign evt_data  = mem[rd_ptr];
   assign full      = (occ == (AW+1)'(DEPTH));
   assign pop       = evt_valid && evt_ready;
   assign do_write  = push && (!full || pop);
   assign drop      = push && full && !pop;

   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr] <= {evt_type, cnt, ts};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         primed   <= 1'b0;
         ts       <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         cnt_q  <= cnt;
         mode_q <= mode;
         primed <= 1'b1;
         ts     <= ts + 1'b1;
         if (do_write)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_write, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based event model.
module tb_count_event_monitor;

   localparam int DEPTH = 4;
   localparam int TS_W  = 12;
   localparam int DW    = 12 + TS_W;

   logic          clk;
   logic          rst;
   logic          mode;
   logic [9:0]    cnt;
   logic          evt_valid;
   logic          evt_ready;
   logic [DW-1:0] evt_data;
   logic          ovf;
   logic [7:0]    drop_cnt;

   int passed = 0;
   int total  = 0;

   count_event_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .cnt       (cnt),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_data  (evt_data),
      .ovf       (ovf),
      .drop_cnt  (drop_cnt)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      else
         passed++;
   endtask

   function automatic logic [31:0] rec(input int ty, input int c, input int t);
      logic [1:0]      ty_b;
      logic [9:0]      c_b;
      logic [TS_W-1:0] t_b;
      ty_b = ty[1:0];
      c_b  = c[9:0];
      t_b  = t[TS_W-1:0];
      return 32'({ty_b, c_b, t_b});
   endfunction

   // driver: apply one sample, then return 1 time unit after the edge that took it
   task automatic step(input logic r, input logic m, input logic [9:0] c, input logic rdy);
      rst       = r;
      mode      = m;
      cnt       = c;
      evt_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // reference model: previous sample, timestamp, expected record queue, drop state
   logic [DW-1:0] exp_q[$];
   int            m_ts;
   int            m_cq;
   logic          m_mq;
   bit            m_primed;
   bit            m_live = 1'b0;
   bit            m_ovf;
   int            m_drop;

   initial begin
      forever begin : model_step
         int   nxt;
         int   ty;
         bit   hit;
         @(posedge clk);
         if (rst) begin
            m_live   = 1'b1;
            exp_q.delete();
            m_ts     = 0;
            m_primed = 1'b0;
            m_ovf    = 1'b0;
            m_drop   = 0;
            m_cq     = 0;
            m_mq     = 1'b0;
         end else if (m_live) begin
            if (exp_q.size() > 0 && evt_ready)
               void'(exp_q.pop_front());
            if (m_primed) begin
               nxt = m_mq ? (m_cq + 1) % 1024 : (m_cq + 1023) % 1024;
               hit = 1'b1;
               ty  = 0;
               if (int'(cnt) != nxt)
                  ty = 2;
               else if ((m_mq && m_cq == 1023) || (!m_mq && m_cq == 0))
                  ty = 0;
               else if (mode != m_mq)
                  ty = 1;
               else
                  hit = 1'b0;
               if (hit) begin
                  if (exp_q.size() < DEPTH)
                     exp_q.push_back(DW'(rec(ty, int'(cnt), m_ts)));
                  else begin
                     m_ovf = 1'b1;
                     if (m_drop < 255)
                        m_drop++;
                  end
               end
            end
            m_cq     = int'(cnt);
            m_mq     = mode;
            m_primed = 1'b1;
            m_ts     = (m_ts + 1) % (1 << TS_W);
         end
      end
   end

   // scoreboard: compare on the falling edge, every cycle after the first reset
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
               check("evt_data", 32'(evt_data), 32'(exp_q[0]));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         end
      end
   end

   initial begin : stim
      logic [9:0] lc;
      logic       lm;
      logic [9:0] c;
      logic       r;
      logic       rdy;
      bit         stall;

      // reset state
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_drop", 32'(drop_cnt), 0);

      // up-count wrap
      step(0, 1, 1021, 1);
      step(0, 1, 1022, 1);
      step(0, 1, 1023, 1);
      check("up_no_early", 32'(evt_valid), 0);
      step(0, 1, 0, 1);
      check("up_valid", 32'(evt_valid), 1);
      check("up_rec", 32'(evt_data), rec(0, 0, 3));
      step(0, 1, 1, 1);
      check("up_single", 32'(evt_valid), 0);

      // down-count wrap
      step(1, 0, 0, 1);
      step(0, 0, 2, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1023, 1);
      check("dn_valid", 32'(evt_valid), 1);
      check("dn_rec", 32'(evt_data), rec(0, 1023, 3));
      step(0, 0, 1022, 1);
      check("dn_single", 32'(evt_valid), 0);

      // direction change: step still follows the previous mode
      step(1, 0, 0, 1);
      step(0, 1, 10, 1);
      step(0, 1, 11, 1);
      step(0, 1, 12, 1);
      step(0, 0, 13, 1);
      check("dir_rec", 32'(evt_data), rec(1, 13, 3));
      step(0, 0, 12, 1);
      check("dir_single", 32'(evt_valid), 0);

      // jump, hold, and jump beating a coincident direction change
      step(1, 0, 0, 1);
      step(0, 1, 100, 1);
      step(0, 1, 200, 1);
      check("jump_rec", 32'(evt_data), rec(2, 200, 1));
      step(0, 1, 200, 1);
      check("hold_rec", 32'(evt_data), rec(2, 200, 2));
      step(0, 1, 1023, 1);
      step(0, 0, 5, 1);
      check("prio_rec", 32'(evt_data), rec(2, 5, 4));
      step(0, 0, 4, 1);
      check("prio_single", 32'(evt_valid), 0);

      // overflow: five events into four slots
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 5; i++)
         step(0, 1, 5, 0);
      check("ovf_set", 32'(ovf), 1);
      check("ovf_drop", 32'(drop_cnt), 1);
      check("ovf_head", 32'(evt_data), rec(2, 5, 1));
      for (int k = 2; k <= 4; k++) begin
         step(0, 1, 10'(4 + k), 1);
         check("ovf_order", 32'(evt_data), rec(2, 5, k));
      end
      step(0, 1, 9, 1);
      check("ovf_drained", 32'(evt_valid), 0);
      check("ovf_sticky", 32'(ovf), 1);

      // reset mid-run with three queued records
      for (int i = 0; i < 3; i++)
         step(0, 1, 9, 0);
      check("mid_valid", 32'(evt_valid), 1);
      step(1, 1, 9, 0);
      check("mid_rst_valid", 32'(evt_valid), 0);
      check("mid_rst_ovf", 32'(ovf), 0);
      check("mid_rst_drop", 32'(drop_cnt), 0);
      step(0, 1, 500, 1);
      check("mid_capture", 32'(evt_valid), 0);
      step(0, 1, 501, 1);
      check("mid_quiet", 32'(evt_valid), 0);
      step(0, 1, 700, 1);
      check("mid_ts_restart", 32'(evt_data), rec(2, 700, 2));

      // drop counter saturation
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      for (int i = 0; i < 265; i++)
         step(0, 1, 0, 0);
      check("sat_drop", 32'(drop_cnt), 255);
      check("sat_ovf", 32'(ovf), 1);

      // randomized traffic
      step(1, 1, 0, 1);
      lc = 10'd1018;
      lm = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         stall = ((i / 250) % 2) == 1;
         r     = ($urandom_range(0, 299) == 0);
         c     = lm ? lc + 10'd1 : lc - 10'd1;
         if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 4))
               0:       c = 10'd1023;
               1:       c = 10'd0;
               2:       c = lc;
               default: c = 10'($urandom_range(0, 1023));
            endcase
         end
         if ($urandom_range(0, 15) == 0)
            lm = ~lm;
         rdy = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
         step(r, lm, c, rdy);
         lc = c;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
